shake_arbiter: RTL and testbench

- Shares the single external SHAKE128 core between two requesters.
  - Requester 0: the Ed25519 signer's SHAKE interface.
  - Requester 1: the host/standalone hash port.
- Captures each request, grants round-robin and runs one SHAKE operation at a time.
- Returns the 512-bit digest to the granted requester with a sticky done level. The signer's wait-then-poll-done protocol works unchanged.

---
 rtl/shake_arbiter.sv | 234 +++++++++++++++++++++++
 tb/tb_shake_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shake_arbiter.sv
// shake_arbiter
// Shares one SHAKE128 core between the Ed25519 signer (requester 0) and the
// host hash port (requester 1). Each request is latched, granted round-robin
// and run on the core one at a time. The digest goes back to the requester
// that issued it, together with a sticky done level.
// Optional build macro: SHAKE_ARB_TIMEOUT_EN adds a core_done watchdog of
// TIMEOUT_CYC cycles that ends a hung operation with a zero digest and err.
module shake_arbiter #(
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          r0_start,
    input  logic [2:0]    r0_type,
    input  logic [1023:0] r0_din,
    input  logic [6:0]    r0_len,
    output logic [511:0]  r0_dout,
    output logic          r0_done,
    input  logic          r1_start,
    input  logic [2:0]    r1_type,
    input  logic [1023:0] r1_din,
    input  logic [6:0]    r1_len,
    output logic [511:0]  r1_dout,
    output logic          r1_done,
    output logic          core_start,
    output logic [2:0]    core_type,
    output logic [1023:0] core_din,
    output logic [6:0]    core_len,
    input  logic [511:0]  core_dout,
    input  logic          core_done,
    output logic [1:0]    grant,
    output logic          busy,
    output logic          err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_LO,
        S_WAIT_DONE,
        S_DELIVER
    } state_t;

    state_t               state_q, state_d;
    logic [1:0]           pend_q, pend_d;
    logic [1:0][2:0]      req_type_q, req_type_d;
    logic [1:0][1023:0]   req_din_q, req_din_d;
    logic [1:0][6:0]      req_len_q, req_len_d;
    logic [1:0][511:0]    dout_q, dout_d;
    logic [1:0]           done_q, done_d;
    logic [1:0]           grant_q, grant_d;
    logic                 last_q, last_d;      // index of the requester served last
    logic                 err_q, err_d;
    logic                 core_start_q, core_start_d;
    logic [2:0]           core_type_q, core_type_d;
    logic [1023:0]        core_din_q, core_din_d;
    logic [6:0]           core_len_q, core_len_d;

    // Requester inputs gathered into arrays so both lanes share one code path
    logic [1:0]           start_w;
    logic [1:0][2:0]      type_w;
    logic [1:0][1023:0]   din_w;
    logic [1:0][6:0]      len_w;
    logic                 sel;                 // requester currently in service
    logic                 pick;                // requester chosen in IDLE

    assign start_w = {r1_start, r0_start};
    assign type_w  = {r1_type, r0_type};
    assign din_w   = {r1_din, r0_din};
    assign len_w   = {r1_len, r0_len};
    assign sel     = grant_q[1];

`ifdef SHAKE_ARB_TIMEOUT_EN
    logic [31:0] tmo_q, tmo_d;
    logic        tmo_hit;

    assign tmo_hit = (tmo_q == 32'(TIMEOUT_CYC - 1));

    // Watchdog counter register, cleared whenever the FSM is not waiting on the core
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    // TIMEOUT_CYC only matters with the watchdog; the empty block keeps the
    // parameter referenced so both builds accept the same override.
    if (TIMEOUT_CYC < 1) begin : g_timeout_unused
    end
`endif

    // State, request latches and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            pend_q       <= '0;
            req_type_q   <= '0;
            req_din_q    <= '0;
            req_len_q    <= '0;
            dout_q       <= '0;
            done_q       <= '0;
            grant_q      <= '0;
            last_q       <= 1'b1;   // so requester 0 wins the first tie
            err_q        <= 1'b0;
            core_start_q <= 1'b0;
            core_type_q  <= '0;
            core_din_q   <= '0;
            core_len_q   <= '0;
        end else begin
            state_q      <= state_d;
            pend_q       <= pend_d;
            req_type_q   <= req_type_d;
            req_din_q    <= req_din_d;
            req_len_q    <= req_len_d;
            dout_q       <= dout_d;
            done_q       <= done_d;
            grant_q      <= grant_d;
            last_q       <= last_d;
            err_q        <= err_d;
            core_start_q <= core_start_d;
            core_type_q  <= core_type_d;
            core_din_q   <= core_din_d;
            core_len_q   <= core_len_d;
        end
    end

    // Request capture, arbitration and operation sequencing
    always_comb begin
        state_d      = state_q;
        pend_d       = pend_q;
        req_type_d   = req_type_q;
        req_din_d    = req_din_q;
        req_len_d    = req_len_q;
        dout_d       = dout_q;
        done_d       = done_q;
        grant_d      = grant_q;
        last_d       = last_q;
        err_d        = err_q;
        core_start_d = 1'b0;
        core_type_d  = core_type_q;
        core_din_d   = core_din_q;
        core_len_d   = core_len_q;
        pick         = 1'b0;
`ifdef SHAKE_ARB_TIMEOUT_EN
        tmo_d        = '0;
`endif

        // A start is accepted only while that requester is idle; a repeated
        // start flags err and leaves its previous result untouched.
        for (int n = 0; n < 2; n++) begin
            if (start_w[n]) begin
                if (pend_q[n] || grant_q[n]) begin
                    err_d = 1'b1;
                end else begin
                    pend_d[n]     = 1'b1;
                    done_d[n]     = 1'b0;
                    req_type_d[n] = type_w[n];
                    req_din_d[n]  = din_w[n];
                    req_len_d[n]  = len_w[n];
                end
            end
        end

        case (state_q)
            S_IDLE: begin
                if (pend_q != 2'b00) begin
                    pick         = (pend_q == 2'b11) ? ~last_q : pend_q[1];
                    grant_d      = pick ? 2'b10 : 2'b01;
                    core_type_d  = req_type_q[pick];
                    core_din_d   = req_din_q[pick];
                    core_len_d   = req_len_q[pick];
                    core_start_d = 1'b1;   // registered: high for the ISSUE cycle
                    state_d      = S_ISSUE;
                end
            end
            S_ISSUE: begin
                pend_d[sel] = 1'b0;
                state_d     = S_WAIT_LO;
            end
            S_WAIT_LO: begin
                // A done still high from the previous operation is stale
                if (!core_done) begin
                    state_d = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (core_done) begin
                    dout_d[sel] = core_dout;
                    state_d     = S_DELIVER;
                end
            end
            S_DELIVER: begin
                done_d[sel] = 1'b1;
                last_d      = sel;
                grant_d     = 2'b00;
                state_d     = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifdef SHAKE_ARB_TIMEOUT_EN
        // A real completion in the expiry cycle still wins over the watchdog
        if (state_q == S_WAIT_LO || (state_q == S_WAIT_DONE && !core_done)) begin
            tmo_d = tmo_q + 32'd1;
            if (tmo_hit) begin
                dout_d[sel] = '0;
                done_d[sel] = 1'b1;
                err_d       = 1'b1;
                last_d      = sel;
                grant_d     = 2'b00;
                state_d     = S_IDLE;
                tmo_d       = '0;
            end
        end
`endif
    end

    assign r0_dout    = dout_q[0];
    assign r1_dout    = dout_q[1];
    assign r0_done    = done_q[0];
    assign r1_done    = done_q[1];
    assign core_start = core_start_q;
    assign core_type  = core_type_q;
    assign core_din   = core_din_q;
    assign core_len   = core_len_q;
    assign grant      = grant_q;
    assign busy       = (state_q != S_IDLE) || (pend_q != 2'b00);
    assign err        = err_q;

endmodule

// File: tb/tb_shake_arbiter.sv
// tb_shake_arbiter: directed bench for shake_arbiter with a small SHAKE core
// model whose digest is a fixed function of the message it was started with.
module tb_shake_arbiter;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          r0_start = 1'b0, r1_start = 1'b0;
    logic [2:0]    r0_type = '0, r1_type = '0;
    logic [1023:0] r0_din = '0, r1_din = '0;
    logic [6:0]    r0_len = '0, r1_len = '0;
    logic [511:0]  r0_dout, r1_dout;
    logic          r0_done, r1_done;
    logic          core_start;
    logic [2:0]    core_type;
    logic [1023:0] core_din;
    logic [6:0]    core_len;
    logic [511:0]  core_dout;
    logic          core_done;
    logic [1:0]    grant;
    logic          busy, err;

    int total = 0;
    int bad = 0;

    // Core model configuration and state
    int            lat_cfg = 20;
    int            hold_cfg = 0;
    bit            never_cfg = 1'b0;
    int            start_cnt = 0;
    int            m_cnt = 0;
    int            m_hold = 0;
    bit            m_run = 1'b0;
    logic [1023:0] m_din = '0;

    shake_arbiter #(.TIMEOUT_CYC(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .r0_start(r0_start), .r0_type(r0_type), .r0_din(r0_din), .r0_len(r0_len),
        .r0_dout(r0_dout), .r0_done(r0_done),
        .r1_start(r1_start), .r1_type(r1_type), .r1_din(r1_din), .r1_len(r1_len),
        .r1_dout(r1_dout), .r1_done(r1_done),
        .core_start(core_start), .core_type(core_type), .core_din(core_din),
        .core_len(core_len), .core_dout(core_dout), .core_done(core_done),
        .grant(grant), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [511:0] digest(input logic [1023:0] m);
        logic [511:0] k;
        k = {16{32'hC3A5_5A3C}};
        return m[1023:512] ^ m[511:0] ^ k;
    endfunction

    function automatic logic [1023:0] mk_din(input logic [31:0] seed);
        logic [1023:0] v;
        for (int i = 0; i < 32; i++) v[i*32 +: 32] = (seed * 32'(i + 1)) ^ 32'h9E37_79B9;
        return v;
    endfunction

    // SHAKE core model: done stays high until the next start, optionally
    // lingering hold_cfg cycles past it; new done after lat_cfg cycles.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_done <= 1'b0;
            core_dout <= '0;
            m_run = 1'b0;
            m_hold = 0;
        end else if (core_start) begin
            start_cnt++;
            m_din = core_din;
            m_cnt = 0;
            m_run = 1'b1;
            m_hold = hold_cfg;
            if (hold_cfg == 0) core_done <= 1'b0;
        end else if (m_run) begin
            m_cnt++;
            if (m_hold > 0) begin
                m_hold--;
                if (m_hold == 0) core_done <= 1'b0;
            end
            if (m_cnt >= lat_cfg && !never_cfg && m_hold == 0) begin
                core_done <= 1'b1;
                core_dout <= digest(m_din);
                m_run = 1'b0;
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic pulse(input int n, input logic [1023:0] d, input logic [6:0] len,
                         input logic [2:0] ty);
        @(negedge clk);
        if (n == 0) begin r0_din = d; r0_len = len; r0_type = ty; r0_start = 1'b1; end
        else        begin r1_din = d; r1_len = len; r1_type = ty; r1_start = 1'b1; end
        @(negedge clk);
        r0_start = 1'b0;
        r1_start = 1'b0;
    endtask

    task automatic wait_core_start(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 100 && !ok; c++) begin
            if (core_start === 1'b1) ok = 1'b1;
            else @(negedge clk);
        end
    endtask

    task automatic wait_done(input int n, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 300 && !ok; c++) begin
            @(negedge clk);
            if ((n == 0 ? r0_done : r1_done) === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        #2;
        total++; if (grant !== 2'b00) begin bad++; $display("FAIL rst_grant: got %b want 00", grant); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        total++; if (core_start !== 1'b0) begin bad++; $display("FAIL rst_core_start: got %b want 0", core_start); end
        total++; if ({r0_done, r1_done, err} !== 3'b000) begin bad++; $display("FAIL rst_done_err: got %b want 000", {r0_done, r1_done, err}); end
        total++; if (r0_dout !== '0) begin bad++; $display("FAIL rst_r0_dout: got %h want 0", r0_dout); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (busy !== 1'b0 || grant !== 2'b00) begin bad++; $display("FAIL rst_idle: busy=%b grant=%b want 0/00", busy, grant); end
    endtask

    task automatic test_single();
        logic [1023:0] d;
        int s0;
        bit seen;
        d = mk_din(32'h1111);
        lat_cfg = 20; hold_cfg = 0; never_cfg = 1'b0;
        s0 = start_cnt;
        @(negedge clk);
        r0_type = 3'd1; r0_len = 7'd32; r0_din = d; r0_start = 1'b1;
        @(negedge clk);
        r0_start = 1'b0;
        total++; if (core_start !== 1'b0) begin bad++; $display("FAIL single_cs_t1: got %b want 0", core_start); end
        @(negedge clk);
        total++; if (core_start !== 1'b1) begin bad++; $display("FAIL single_cs_t2: got %b want 1", core_start); end
        total++; if (core_din !== d) begin bad++; $display("FAIL single_core_din: got %h want %h", core_din, d); end
        total++; if (core_len !== 7'd32 || core_type !== 3'd1) begin bad++; $display("FAIL single_len_type: got %0d/%0d want 32/1", core_len, core_type); end
        total++; if (grant !== 2'b01) begin bad++; $display("FAIL single_grant: got %b want 01", grant); end
        @(negedge clk);
        total++; if (core_start !== 1'b0) begin bad++; $display("FAIL single_cs_t3: got %b want 0", core_start); end
        seen = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(negedge clk);
            if (core_done === 1'b1) seen = 1'b1;
        end
        total++; if (!seen) begin bad++; $display("FAIL single_core_done_wait: got none want core_done within 100"); end
        @(negedge clk);
        total++; if (r0_done !== 1'b0) begin bad++; $display("FAIL single_done_early: got %b want 0", r0_done); end
        @(negedge clk);
        total++; if (r0_done !== 1'b1) begin bad++; $display("FAIL single_done: got %b want 1", r0_done); end
        total++; if (r0_dout !== digest(d)) begin bad++; $display("FAIL single_dout: got %h want %h", r0_dout, digest(d)); end
        total++; if (grant !== 2'b00) begin bad++; $display("FAIL single_grant_end: got %b want 00", grant); end
        total++; if (core_din !== d) begin bad++; $display("FAIL single_din_stable: got %h want %h", core_din, d); end
        repeat (5) @(negedge clk);
        total++; if (r0_done !== 1'b1) begin bad++; $display("FAIL single_done_held: got %b want 1", r0_done); end
        total++; if (start_cnt - s0 != 1) begin bad++; $display("FAIL single_start_count: got %0d want 1", start_cnt - s0); end
    endtask

    task automatic test_simultaneous();
        logic [1023:0] d0, d1;
        logic [1:0] first_g, second_g, prev_g;
        int t0, t1;
        do_reset();
        d0 = mk_din(32'h2222); d1 = mk_din(32'h3333);
        lat_cfg = 8;
        first_g = '0; second_g = '0; prev_g = '0; t0 = -1; t1 = -1;
        @(negedge clk);
        r0_din = d0; r0_len = 7'd64; r0_type = 3'd0; r0_start = 1'b1;
        r1_din = d1; r1_len = 7'd17; r1_type = 3'd1; r1_start = 1'b1;
        @(negedge clk);
        r0_start = 1'b0; r1_start = 1'b0;
        for (int c = 0; c < 200 && (t0 < 0 || t1 < 0); c++) begin
            @(negedge clk);
            if (grant != 2'b00 && grant != prev_g) begin
                if (first_g == 2'b00) first_g = grant;
                else if (second_g == 2'b00) second_g = grant;
            end
            prev_g = grant;
            if (r0_done === 1'b1 && t0 < 0) t0 = c;
            if (r1_done === 1'b1 && t1 < 0) t1 = c;
        end
        total++; if (first_g !== 2'b01) begin bad++; $display("FAIL sim_first_grant: got %b want 01", first_g); end
        total++; if (second_g !== 2'b10) begin bad++; $display("FAIL sim_second_grant: got %b want 10", second_g); end
        total++; if (t0 < 0 || t1 < 0 || t0 >= t1) begin bad++; $display("FAIL sim_done_order: got t0=%0d t1=%0d want 0<=t0<t1", t0, t1); end
        total++; if (r0_dout !== digest(d0)) begin bad++; $display("FAIL sim_r0_dout: got %h want %h", r0_dout, digest(d0)); end
        total++; if (r1_dout !== digest(d1)) begin bad++; $display("FAIL sim_r1_dout: got %h want %h", r1_dout, digest(d1)); end
    endtask

    task automatic test_round_robin();
        logic [1:0] last_g, prev_g, exp_g;
        int rem0, rem1, events;
        bit ok;
        lat_cfg = 6;
        pulse(1, mk_din(32'h4444), 7'd10, 3'd0);
        wait_done(1, ok);
        total++; if (!ok) begin bad++; $display("FAIL rr_r1_alone: got no done want r1_done"); end
        last_g = 2'b10; prev_g = 2'b00; events = 0; rem0 = 7; rem1 = 7;
        @(negedge clk);
        r0_din = mk_din(32'h5555); r1_din = mk_din(32'h6666);
        r0_start = 1'b1; r1_start = 1'b1;
        for (int c = 0; c < 3000 && events < 16; c++) begin
            @(negedge clk);
            r0_start = 1'b0; r1_start = 1'b0;
            if (grant != 2'b00 && prev_g == 2'b00) begin
                events++;
                exp_g = (last_g == 2'b01) ? 2'b10 : 2'b01;
                total++; if (grant !== exp_g) begin bad++; $display("FAIL rr_grant_%0d: got %b want %b", events, grant, exp_g); end
                last_g = grant;
            end
            prev_g = grant;
            if (r0_done === 1'b1 && rem0 > 0) begin r0_start = 1'b1; rem0--; end
            if (r1_done === 1'b1 && rem1 > 0) begin r1_start = 1'b1; rem1--; end
        end
        total++; if (events != 16) begin bad++; $display("FAIL rr_op_count: got %0d want 16", events); end
        wait_done(1, ok);
        total++; if (r1_dout !== digest(mk_din(32'h6666))) begin bad++; $display("FAIL rr_r1_dout: got %h want %h", r1_dout, digest(mk_din(32'h6666))); end
    endtask

    task automatic test_stale_done();
        logic [1023:0] d;
        int cs_t, dn_t;
        bit ok;
        d = mk_din(32'h7777);
        hold_cfg = 3; lat_cfg = 10;
        total++; if (core_done !== 1'b1) begin bad++; $display("FAIL stale_precond: got core_done=%b want 1", core_done); end
        pulse(0, d, 7'd100, 3'd1);
        wait_core_start(ok);
        cs_t = 0; dn_t = -1;
        for (int c = 1; c < 100 && dn_t < 0; c++) begin
            @(negedge clk);
            if (r0_done === 1'b1) dn_t = c;
        end
        total++; if (!ok || dn_t < 12) begin bad++; $display("FAIL stale_early: got done at %0d want >= 12 after core_start", dn_t); end
        total++; if (r0_dout !== digest(d)) begin bad++; $display("FAIL stale_dout: got %h want %h", r0_dout, digest(d)); end
        hold_cfg = 0;
    endtask

    task automatic test_start_busy();
        logic [1023:0] d, d2;
        int s0;
        bit ok;
        do_reset();
        d = mk_din(32'h8888); d2 = mk_din(32'h9999);
        lat_cfg = 30;
        s0 = start_cnt;
        pulse(0, d, 7'd48, 3'd1);
        wait_core_start(ok);
        repeat (10) @(negedge clk);
        total++; if (err !== 1'b0) begin bad++; $display("FAIL busy_err_before: got %b want 0", err); end
        pulse(0, d2, 7'd5, 3'd0);
        total++; if (err !== 1'b1) begin bad++; $display("FAIL busy_err: got %b want 1", err); end
        total++; if (core_din !== d) begin bad++; $display("FAIL busy_core_din: got %h want %h", core_din, d); end
        wait_done(0, ok);
        total++; if (!ok || r0_dout !== digest(d)) begin bad++; $display("FAIL busy_dout: got %h want %h", r0_dout, digest(d)); end
        repeat (5) @(negedge clk);
        total++; if (start_cnt - s0 != 1 || busy !== 1'b0) begin bad++; $display("FAIL busy_extra_op: got starts=%0d busy=%b want 1/0", start_cnt - s0, busy); end
    endtask

    task automatic test_reset_mid();
        logic [1023:0] d;
        int s0;
        bit ok;
        lat_cfg = 30;
        pulse(1, mk_din(32'hAAAA), 7'd20, 3'd0);
        wait_core_start(ok);
        repeat (10) @(negedge clk);
        pulse(0, mk_din(32'hBBBB), 7'd20, 3'd0);
        #2 rst_n = 1'b0;
        #1;
        total++; if (grant !== 2'b00 || busy !== 1'b0) begin bad++; $display("FAIL mid_rst_grant_busy: got %b/%b want 00/0", grant, busy); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL mid_rst_err: got %b want 0", err); end
        total++; if (r0_dout !== '0 || core_din !== '0) begin bad++; $display("FAIL mid_rst_data: got r0_dout=%h want 0", r0_dout); end
        @(negedge clk);
        rst_n = 1'b1;
        s0 = start_cnt;
        repeat (6) @(negedge clk);
        total++; if (start_cnt != s0 || busy !== 1'b0) begin bad++; $display("FAIL mid_rst_pending_dropped: got starts=%0d busy=%b want 0/0", start_cnt - s0, busy); end
        d = mk_din(32'hCCCC);
        lat_cfg = 8;
        pulse(0, d, 7'd33, 3'd1);
        wait_done(0, ok);
        total++; if (!ok || r0_dout !== digest(d)) begin bad++; $display("FAIL mid_rst_next_req: got %h want %h", r0_dout, digest(d)); end
    endtask

`ifdef SHAKE_ARB_TIMEOUT_EN
    task automatic test_timeout();
        logic [1023:0] d0, d1;
        int c_done;
        bit ok;
        do_reset();
        lat_cfg = 8; never_cfg = 1'b0;
        pulse(1, mk_din(32'hDDDD), 7'd8, 3'd0);
        wait_done(1, ok);
        d0 = mk_din(32'hEEEE); d1 = mk_din(32'hFFFF);
        never_cfg = 1'b1;
        pulse(1, d1, 7'd9, 3'd0);
        wait_core_start(ok);
        pulse(0, d0, 7'd9, 3'd1);
        c_done = 2;
        while (r1_done !== 1'b1 && c_done < 300) begin
            @(negedge clk);
            c_done++;
        end
        never_cfg = 1'b0;
        total++; if (c_done < 64 || c_done > 66) begin bad++; $display("FAIL tmo_latency: got %0d want 64..66", c_done); end
        total++; if (r1_dout !== '0) begin bad++; $display("FAIL tmo_dout: got %h want 0", r1_dout); end
        total++; if (err !== 1'b1) begin bad++; $display("FAIL tmo_err: got %b want 1", err); end
        wait_done(0, ok);
        total++; if (!ok || r0_dout !== digest(d0)) begin bad++; $display("FAIL tmo_next_r0: got %h want %h", r0_dout, digest(d0)); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_round_robin();
        test_stale_done();
        test_start_busy();
        test_reset_mid();
`ifdef SHAKE_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
